// File: rtl/m_pipelined_mac.sv
// rtl/m_pipelined_mac.sv - three-register pipelined unsigned multiply-add / accumulate unit
module m_pipelined_mac #(
    parameter int A_W = 16,
    parameter int B_W = 16,
    parameter int Y_W = 32,
    parameter bit SAT = 1'b1
) (
    input  logic           w_clock,
    input  logic           w_reset,
    input  logic           w_valid,
    input  logic           w_mode,
    input  logic           w_clear,
    input  logic [A_W-1:0] w_a,
    input  logic [B_W-1:0] w_b,
    input  logic [Y_W-1:0] w_c,
    output logic [Y_W-1:0] r_y,
    output logic           r_valid,
    output logic [Y_W-1:0] r_acc,
    output logic           r_ovf
);

    localparam int P_W = A_W + B_W;
    localparam int PAD = Y_W + 1 - P_W;

    // Stage 1: raw input capture
    logic           valid1_q;
    logic           mode1_q;
    logic           clear1_q;
    logic [A_W-1:0] a1_q;
    logic [B_W-1:0] b1_q;
    logic [Y_W-1:0] c1_q;

    // Stage 2: product plus the control and addend that travel alongside it
    logic           valid2_q;
    logic           mode2_q;
    logic           clear2_q;
    logic [Y_W:0]   p2_q;
    logic [Y_W-1:0] c2_q;
    logic [Y_W:0]   p2_d;
    logic [P_W-1:0] prod;

    // Output stage: result, accumulator and sticky overflow
    logic [Y_W-1:0] y_q;
    logic           valid_q;
    logic [Y_W-1:0] acc_q;
    logic           ovf_q;
    logic [Y_W-1:0] y_d;
    logic           valid_d;
    logic [Y_W-1:0] acc_d;
    logic           ovf_d;

    logic [Y_W:0]   base;
    logic [Y_W:0]   sum;
    logic           hit;
    logic [Y_W-1:0] res;

    // Capture every input on every edge; validity is carried as data
    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            valid1_q <= 1'b0;
            mode1_q  <= 1'b0;
            clear1_q <= 1'b0;
            a1_q     <= '0;
            b1_q     <= '0;
            c1_q     <= '0;
        end else begin
            valid1_q <= w_valid;
            mode1_q  <= w_mode;
            clear1_q <= w_clear;
            a1_q     <= w_a;
            b1_q     <= w_b;
            c1_q     <= w_c;
        end
    end

    // Full-width product, zero-extended so the final add has a carry bit
    always_comb begin
        prod = {{B_W{1'b0}}, a1_q} * {{A_W{1'b0}}, b1_q};
        p2_d = {{PAD{1'b0}}, prod};
    end

    // Register the product so the accumulate add sits alone in the last stage
    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            valid2_q <= 1'b0;
            mode2_q  <= 1'b0;
            clear2_q <= 1'b0;
            p2_q     <= '0;
            c2_q     <= '0;
        end else begin
            valid2_q <= valid1_q;
            mode2_q  <= mode1_q;
            clear2_q <= clear1_q;
            p2_q     <= p2_d;
            c2_q     <= c1_q;
        end
    end

    // Final add reads acc_q directly, so back-to-back accumulates chain with no forwarding
    always_comb begin
        if (mode2_q) begin
            base = clear2_q ? '0 : {1'b0, acc_q};
        end else begin
            base = {1'b0, c2_q};
        end
        sum = p2_q + base;
        hit = sum[Y_W];
        res = (hit && SAT) ? '1 : sum[Y_W-1:0];

        y_d     = y_q;
        valid_d = 1'b0;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (valid2_q) begin
            valid_d = 1'b1;
            y_d     = res;
            if (mode2_q) begin
                acc_d = res;
            end else if (clear2_q) begin
                acc_d = '0;
            end
            // A clear restarts the sticky flag, but this operation's own overflow still lands
            ovf_d = clear2_q ? hit : (ovf_q | hit);
        end else if (clear2_q) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            y_q     <= '0;
            valid_q <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign r_y     = y_q;
    assign r_valid = valid_q;
    assign r_acc   = acc_q;
    assign r_ovf   = ovf_q;

endmodule

// File: tb/tb_m_pipelined_mac.sv
// tb/tb_m_pipelined_mac.sv - directed self-checking bench for m_pipelined_mac (saturating and wrapping instances)
module tb_m_pipelined_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic        mode;
    logic        clr;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] c;

    logic [31:0] y_s, acc_s, y_w, acc_w;
    logic        vo_s, ovf_s, vo_w, ovf_w;

    int nvec = 0;
    int nerr = 0;

    logic        sq_m   [8];
    logic        sq_cl  [8];
    logic [15:0] sq_a   [8];
    logic [15:0] sq_b   [8];
    logic [31:0] sq_c   [8];
    logic [31:0] sq_y   [8];
    logic [31:0] sq_acc [8];

    always #5 clk = ~clk;

    m_pipelined_mac #(.A_W(16), .B_W(16), .Y_W(32), .SAT(1'b1)) u_sat (
        .w_clock(clk), .w_reset(rst), .w_valid(vld), .w_mode(mode), .w_clear(clr),
        .w_a(a), .w_b(b), .w_c(c),
        .r_y(y_s), .r_valid(vo_s), .r_acc(acc_s), .r_ovf(ovf_s)
    );

    m_pipelined_mac #(.A_W(16), .B_W(16), .Y_W(32), .SAT(1'b0)) u_wrap (
        .w_clock(clk), .w_reset(rst), .w_valid(vld), .w_mode(mode), .w_clear(clr),
        .w_a(a), .w_b(b), .w_c(c),
        .r_y(y_w), .r_valid(vo_w), .r_acc(acc_w), .r_ovf(ovf_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic cl,
                         input logic [15:0] aa, input logic [15:0] bb, input logic [31:0] cc);
        vld = v; mode = m; clr = cl; a = aa; b = bb; c = cc;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 32'd0);
    endtask

    task automatic set_s(input int i, input logic m, input logic cl, input logic [15:0] aa,
                         input logic [15:0] bb, input logic [31:0] cc,
                         input logic [31:0] ey, input logic [31:0] ea);
        sq_m[i] = m; sq_cl[i] = cl; sq_a[i] = aa; sq_b[i] = bb; sq_c[i] = cc;
        sq_y[i] = ey; sq_acc[i] = ea;
    endtask

    // One sample per cycle; sample i must appear exactly on the third edge after it is driven
    task automatic run_seq(input string tag, input int n);
        for (int i = 0; i < n + 3; i++) begin
            if (i < n) drive(1'b1, sq_m[i], sq_cl[i], sq_a[i], sq_b[i], sq_c[i]);
            else idle;
            tick;
            if (i >= 2 && i - 2 < n) begin
                chk($sformatf("%s_vld%0d", tag, i - 2), {31'd0, vo_s}, 32'd1);
                chk($sformatf("%s_y%0d", tag, i - 2), y_s, sq_y[i - 2]);
                chk($sformatf("%s_yw%0d", tag, i - 2), y_w, sq_y[i - 2]);
                chk($sformatf("%s_acc%0d", tag, i - 2), acc_s, sq_acc[i - 2]);
            end else begin
                chk($sformatf("%s_novld%0d", tag, i), {31'd0, vo_s}, 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        idle;

        // Asynchronous reset takes effect without a clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_y", y_s, 32'd0);
        chk("rst_vld", {31'd0, vo_s}, 32'd0);
        chk("rst_acc", acc_s, 32'd0);
        chk("rst_ovf", {31'd0, ovf_s}, 32'd0);
        chk("rst_yw", y_w, 32'd0);
        tick;
        tick;
        rst = 1'b0;

        // Mode 0 stream
        set_s(0, 1'b0, 1'b0, 16'd3, 16'd1, 32'd2, 32'd5, 32'd0);
        set_s(1, 1'b0, 1'b0, 16'd3, 16'd3, 32'd4, 32'd13, 32'd0);
        set_s(2, 1'b0, 1'b0, 16'd3, 16'd5, 32'd6, 32'd21, 32'd0);
        set_s(3, 1'b0, 1'b0, 16'd3, 16'd7, 32'd8, 32'd29, 32'd0);
        run_seq("m0", 4);
        chk("m0_yhold", y_s, 32'd29);

        // Mode 1 chained accumulate, first sample clears
        set_s(0, 1'b1, 1'b1, 16'd2, 16'd3, 32'd0, 32'd6, 32'd6);
        set_s(1, 1'b1, 1'b0, 16'd4, 16'd5, 32'd0, 32'd26, 32'd26);
        set_s(2, 1'b1, 1'b0, 16'd6, 16'd7, 32'd0, 32'd68, 32'd68);
        run_seq("m1", 3);

        // Clear-only, then interleaved modes
        drive(1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 32'd0);
        tick;
        set_s(0, 1'b1, 1'b0, 16'd1, 16'd10, 32'd0, 32'd10, 32'd10);
        set_s(1, 1'b0, 1'b0, 16'd2, 16'd2, 32'd1, 32'd5, 32'd10);
        set_s(2, 1'b1, 1'b0, 16'd1, 16'd5, 32'd0, 32'd15, 32'd15);
        run_seq("mix", 3);

        // Mode 0 overflow: saturate vs wrap
        drive(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF);
        tick;
        idle;
        tick;
        tick;
        chk("ovf0_ys", y_s, 32'hFFFF_FFFF);
        chk("ovf0_yw", y_w, 32'hFFFE_0000);
        chk("ovf0_fs", {31'd0, ovf_s}, 32'd1);
        chk("ovf0_fw", {31'd0, ovf_w}, 32'd1);
        chk("ovf0_acc", acc_s, 32'd15);

        // Clear-only drops overflow and accumulator, leaves r_y alone
        drive(1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 32'd0);
        tick;
        idle;
        tick;
        tick;
        chk("clr_ovf", {31'd0, ovf_s}, 32'd0);
        chk("clr_acc", acc_s, 32'd0);
        chk("clr_ys", y_s, 32'hFFFF_FFFF);
        chk("clr_yw", y_w, 32'hFFFE_0000);
        chk("clr_vld", {31'd0, vo_s}, 32'd0);

        // Accumulate overflow, sticky flag, clear-with-valid in both modes
        drive(1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 32'd0);
        tick;
        drive(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'd0);
        tick;
        drive(1'b1, 1'b0, 1'b0, 16'd1, 16'd1, 32'd1);
        tick;
        chk("acc1_y", y_s, 32'hFFFE_0001);
        chk("acc1_ovf", {31'd0, ovf_s}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 16'd1, 16'd1, 32'd0);
        tick;
        chk("acc2_ys", y_s, 32'hFFFF_FFFF);
        chk("acc2_yw", y_w, 32'hFFFC_0002);
        chk("acc2_as", acc_s, 32'hFFFF_FFFF);
        chk("acc2_aw", acc_w, 32'hFFFC_0002);
        chk("acc2_ovf", {31'd0, ovf_s}, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 16'd2, 16'd2, 32'd0);
        tick;
        chk("sticky_y", y_s, 32'd2);
        chk("sticky_ovf", {31'd0, ovf_s}, 32'd1);
        chk("sticky_acc", acc_s, 32'hFFFF_FFFF);
        idle;
        tick;
        chk("clr1_y", y_s, 32'd1);
        chk("clr1_acc", acc_s, 32'd1);
        chk("clr1_ovf", {31'd0, ovf_s}, 32'd0);
        tick;
        chk("clr0_y", y_s, 32'd4);
        chk("clr0_acc", acc_s, 32'd0);
        chk("clr0_ovf", {31'd0, ovf_s}, 32'd0);
        tick;
        chk("clr0_novld", {31'd0, vo_s}, 32'd0);

        // Reset between edges with two samples in flight
        drive(1'b1, 1'b0, 1'b0, 16'd5, 16'd5, 32'd5);
        tick;
        drive(1'b1, 1'b1, 1'b0, 16'd6, 16'd6, 32'd6);
        tick;
        idle;
        #2 rst = 1'b1;
        #1;
        chk("mrst_y", y_s, 32'd0);
        chk("mrst_vld", {31'd0, vo_s}, 32'd0);
        chk("mrst_acc", acc_s, 32'd0);
        chk("mrst_ovf", {31'd0, ovf_s}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 16'd1, 16'd1, 32'd1);
        tick;
        chk("post_novld0", {31'd0, vo_s}, 32'd0);
        idle;
        tick;
        chk("post_novld1", {31'd0, vo_s}, 32'd0);
        chk("post_acc", acc_s, 32'd0);
        tick;
        chk("post_vld", {31'd0, vo_s}, 32'd1);
        chk("post_y", y_s, 32'd2);
        tick;
        chk("post_end", {31'd0, vo_s}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/m_pipelined_mac.md
M_PIPELINED_MAC -- requirements
Module: m_pipelined_mac

Interface
REQ-001 The block SHALL take parameters (name, default, meaning), one per line:
- A_W, 16: width of operand w_a.
- B_W, 16: width of operand w_b.
- Y_W, 32: width of addend, accumulator and result. A_W+B_W <= Y_W is required.
- SAT, 1: 1 = saturate on overflow, 0 = wrap modulo 2^Y_W.

REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-high.

REQ-003 The block SHALL have these ports (name, direction, width, meaning), one per line:
- w_clock, in, 1: rising-edge clock.
- w_reset, in, 1: asynchronous active-high reset.
- w_valid, in, 1: input sample valid this cycle.
- w_mode, in, 1: 0 = multiply-add (a*b+c), 1 = accumulate (acc+a*b).
- w_clear, in, 1: zero accumulator and overflow flag.
- w_a, in, A_W: unsigned multiplicand.
- w_b, in, B_W: unsigned multiplier.
- w_c, in, Y_W: unsigned addend, used in mode 0 only.
- r_y, out, Y_W: registered result.
- r_valid, out, 1: r_y updated this cycle.
- r_acc, out, Y_W: current accumulator value.
- r_ovf, out, 1: sticky overflow flag.

Function
REQ-004 Stage 1 SHALL register w_valid, w_mode, w_clear, w_a, w_b and w_c on every rising edge, unconditionally.
REQ-005 Stage 2 SHALL compute p = a1*b1 at A_W+B_W bits, zero-extended to Y_W+1 bits, from the stage-1 registers.
REQ-006 Latency SHALL be exactly 2 cycles: r_valid is high on edge N+2 for a w_valid sampled at edge N. Throughput SHALL be one sample per cycle with no stalls and no bubbles inserted.
REQ-007 Mode 0 with valid1: s = p + c1 (Y_W+1 bits); r_y <= f(s); r_acc unchanged.
REQ-008 Mode 1 with valid1: base = 0 if clear1 else r_acc; s = p + base; r_y <= f(s); r_acc <= f(s).
REQ-009 f(s) SHALL behave as follows:
- If s[Y_W] = 0: result is s[Y_W-1:0].
- Otherwise, SAT=1: result is all ones.
- Otherwise, SAT=0: result is s[Y_W-1:0].
REQ-010 Overflow (s[Y_W] = 1) in any valid operation SHALL set r_ovf on the same edge as r_y, regardless of SAT.
REQ-011 clear1 with valid1 low SHALL set r_acc <= 0 and r_ovf <= 0; r_y and r_valid SHALL be unaffected by that clear.
REQ-012 clear1 with valid1 high, mode 1: r_ovf <= 0, unless this operation itself overflows, in which case r_ovf <= 1 (the set wins).
REQ-013 clear1 with valid1 high, mode 0: r_acc <= 0 and r_ovf <= overflow of this operation; r_y is per REQ-007.
REQ-014 With valid1 low, r_y SHALL hold its previous value and r_valid SHALL be 0.
REQ-015 Back-to-back mode-1 samples SHALL chain: each accumulate uses the r_acc written by the immediately preceding accumulate, with no hazard or lost update.
REQ-016 Mode switches between consecutive samples SHALL take effect per sample with no extra latency.

Reset
REQ-017 When w_reset is asserted, all stage-1 registers, r_y, r_acc, r_valid and r_ovf SHALL go to 0 immediately, without waiting for a clock edge.
REQ-018 A sample in flight when reset asserts SHALL be discarded: no r_valid pulse after reset release unless w_valid is re-driven.
REQ-019 The first w_valid sampled on the first rising edge after reset deassertion SHALL be processed normally.

Verification
REQ-020 Mode 0, one sample per cycle, (a,b,c) = (3,1,2), (3,3,4), (3,5,6), (3,7,8) -> r_y = 5, 13, 21, 29 on consecutive cycles starting 2 cycles after the first input; r_valid high for exactly 4 cycles; r_acc = 0.
REQ-021 Mode 1, first sample with clear, (a,b) = (2,3), (4,5), (6,7) -> r_y = r_acc = 6, 26, 68, back-to-back.
REQ-022 SAT=1, Y_W=32, mode 0, a = b = 0xFFFF, c = 0xFFFFFFFF -> r_y = 0xFFFFFFFF, r_ovf = 1. Then a clear-only cycle -> r_ovf = 0, r_acc = 0, r_y unchanged.
REQ-023 SAT=0, same stimulus as REQ-022 -> r_y = 0xFFFE0000, r_ovf = 1.
REQ-024 Reset mid-stream: assert w_reset between clock edges while 2 valid samples are in flight -> all outputs 0 immediately, no r_valid after release; a new sample (1,1,1) in mode 0 -> r_y = 2 two cycles later.
REQ-025 Interleaved stream (mode 1: 1*10), (mode 0: 2*2+1), (mode 1: 1*5), no clear, accumulator 0 at start -> r_y = 10, 5, 15; final r_acc = 15.
